// File: rtl/hall_call_panel.sv
// Hall-call panel: synchronizes and debounces the landing UP/DOWN buttons.
// Accepted presses are latched as pending calls for the elevator controller.
// A latched call clears when the car serves it: door open at that floor,
// with a compatible direction.
module hall_call_panel #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] up_btn,
    input  logic [NUM_FLOORS-1:0] down_btn,
    input  logic [1:0]            current_floor,
    input  logic [1:0]            direction,
    input  logic                  door_state,
    output logic [NUM_FLOORS-1:0] move_up_call,
    output logic [NUM_FLOORS-1:0] move_down_call,
    output logic [NUM_FLOORS-1:0] up_lamp,
    output logic [NUM_FLOORS-1:0] down_lamp,
    output logic                  call_pending
);

    // Buttons are handled as one vector: UP in the low half, DOWN in the high half.
    localparam int NB = 2 * NUM_FLOORS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The top-floor UP and ground-floor DOWN buttons do not exist.
    localparam logic [NB-1:0] USED =
        ~((NB'(1) << (NUM_FLOORS - 1)) | (NB'(1) << NUM_FLOORS));

    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    sync_p0;
    logic [NB-1:0]    sync_p1;
    logic [CNT_W-1:0] cnt_p2 [NB];
    logic [NB-1:0]    armed_p2;
    logic [NB-1:0]    press_p2;

    logic [NUM_FLOORS-1:0] clr_up;
    logic [NUM_FLOORS-1:0] clr_dn;
    logic                  up_ok;
    logic                  dn_ok;

    assign btn_raw = {down_btn, up_btn};

    // Stage p0/p1: two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: saturating debounce counter; one press pulse per stable assertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                cnt_p2[i] <= '0;
            end
            armed_p2 <= '0;
            press_p2 <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!sync_p1[i]) begin
                    cnt_p2[i]   <= '0;
                    armed_p2[i] <= 1'b1;
                    press_p2[i] <= 1'b0;
                end else begin
                    if (cnt_p2[i] != CNT_MAX) begin
                        cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                    end
                    // The armed flag drops even on an unused button, so it never fires later.
                    press_p2[i] <= armed_p2[i] && (cnt_p2[i] == CNT_PRE) && USED[i];
                    if (armed_p2[i] && (cnt_p2[i] == CNT_PRE)) begin
                        armed_p2[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Serve condition: door open at the car's floor with a compatible direction (11 acts as idle).
    always_comb begin
        clr_up = '0;
        clr_dn = '0;
        up_ok  = (direction != 2'b10);
        dn_ok  = (direction != 2'b01);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (door_state && (int'(current_floor) == i)) begin
                clr_up[i] = up_ok;
                clr_dn[i] = dn_ok;
            end
        end
    end

    // Stage p3: call latches; a clear in the same cycle as a press wins and consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_up_call   <= '0;
            move_down_call <= '0;
        end else begin
            move_up_call   <= (move_up_call | press_p2[NUM_FLOORS-1:0]) & ~clr_up;
            move_down_call <= (move_down_call | press_p2[NB-1:NUM_FLOORS]) & ~clr_dn;
        end
    end

    assign up_lamp      = move_up_call;
    assign down_lamp    = move_down_call;
    assign call_pending = (|move_up_call) | (|move_down_call);

endmodule

// File: tb/tb_hall_call_panel.sv
// Directed bench for hall_call_panel: one table row per clock cycle, holding the
// inputs applied before the edge and the call state expected just after it.
module tb_hall_call_panel;

    logic       clk;
    logic       rst;
    logic [3:0] up_btn;
    logic [3:0] down_btn;
    logic [1:0] current_floor;
    logic [1:0] direction;
    logic       door_state;
    logic [3:0] move_up_call;
    logic [3:0] move_down_call;
    logic [3:0] up_lamp;
    logic [3:0] down_lamp;
    logic       call_pending;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] up;
        logic [3:0] dn;
        logic [1:0] fl;
        logic [1:0] dir;
        logic       door;
        logic [3:0] eu;
        logic [3:0] ed;
    } vec_t;

    vec_t vecs[$];

    hall_call_panel #(
        .NUM_FLOORS(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_btn(up_btn),
        .down_btn(down_btn),
        .current_floor(current_floor),
        .direction(direction),
        .door_state(door_state),
        .move_up_call(move_up_call),
        .move_down_call(move_down_call),
        .up_lamp(up_lamp),
        .down_lamp(down_lamp),
        .call_pending(call_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [3:0] up, input logic [3:0] dn, input logic [1:0] fl,
                       input logic [1:0] dir, input logic door, input logic [3:0] eu,
                       input logic [3:0] ed, input int n);
        vec_t v;
        v.up = up; v.dn = dn; v.fl = fl; v.dir = dir; v.door = door; v.eu = eu; v.ed = ed;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] eu, input logic [3:0] ed);
        logic [16:0] act;
        logic [16:0] exp;
        act = {move_up_call, move_down_call, up_lamp, down_lamp, call_pending};
        exp = {eu, ed, eu, ed, (|eu) | (|ed)};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got up/dn/lamps/pend=%h want %h", name, act, exp);
    endtask

    initial begin
        // Scenario 1: up_btn[1] held through reset, accepted on edge 7 after release
        add(4'b0010, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0000, 4'b0000, 6);
        add(4'b0010, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 1);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 3);
        // Scenario 2: 3-cycle glitch on up_btn[2] ignored, then a 10-cycle hold latches
        add(4'b0100, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 3);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 5);
        add(4'b0100, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 6);
        add(4'b0100, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0110, 4'b0000, 4);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0110, 4'b0000, 3);
        // Scenario 3: down[3] kept when served going up, cleared when served going down
        add(4'b0000, 4'b1000, 2'd0, 2'b01, 1'b0, 4'b0110, 4'b0000, 6);
        add(4'b0000, 4'b1000, 2'd0, 2'b01, 1'b0, 4'b0110, 4'b1000, 1);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0110, 4'b1000, 3);
        add(4'b0000, 4'b0000, 2'd3, 2'b01, 1'b1, 4'b0110, 4'b1000, 2);
        add(4'b0000, 4'b0000, 2'd3, 2'b10, 1'b1, 4'b0110, 4'b0000, 1);
        add(4'b0000, 4'b0000, 2'd3, 2'b10, 1'b0, 4'b0110, 4'b0000, 1);
        // Scenario 4: clear up[2] idle at floor 2, latch down[1], serve floor 1 up then idle
        add(4'b0000, 4'b0000, 2'd2, 2'b00, 1'b1, 4'b0010, 4'b0000, 1);
        add(4'b0000, 4'b0000, 2'd2, 2'b00, 1'b0, 4'b0010, 4'b0000, 1);
        add(4'b0000, 4'b0010, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 6);
        add(4'b0000, 4'b0010, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0010, 1);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0010, 3);
        add(4'b0000, 4'b0000, 2'd1, 2'b01, 1'b1, 4'b0000, 4'b0010, 1);
        add(4'b0000, 4'b0000, 2'd1, 2'b00, 1'b1, 4'b0000, 4'b0000, 1);
        add(4'b0000, 4'b0000, 2'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 1);
        // Scenario 5: acceptance coincides with serve -> consumed; held press stays dead
        add(4'b0010, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0000, 4'b0000, 6);
        add(4'b0010, 4'b0000, 2'd1, 2'b00, 1'b1, 4'b0000, 4'b0000, 1);
        add(4'b0010, 4'b0000, 2'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 5);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0000, 4'b0000, 3);
        add(4'b0010, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0000, 4'b0000, 6);
        add(4'b0010, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 1);
        add(4'b0000, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 2);
        // Scenario 6: nonexistent buttons up[3] and down[0] never latch
        add(4'b1000, 4'b0001, 2'd0, 2'b01, 1'b0, 4'b0010, 4'b0000, 20);

        rst = 1'b0;
        up_btn = 4'b0010;
        down_btn = 4'b0000;
        current_floor = 2'd0;
        direction = 2'b01;
        door_state = 1'b0;

        // Reset held across edges with a button pressed: everything stays 0
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 4'b0000);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            up_btn        = vecs[k].up;
            down_btn      = vecs[k].dn;
            current_floor = vecs[k].fl;
            direction     = vecs[k].dir;
            door_state    = vecs[k].door;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", k), vecs[k].eu, vecs[k].ed);
        end

        // Asynchronous reset with a call latched clears outputs before any edge
        check("before_async_rst", 4'b0010, 4'b0000);
        rst = 1'b0;
        #2;
        check("async_rst", 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        check("async_rst_edge", 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
